// File: rtl/fft_power_peak.sv
// Per-bin power (re^2 + im^2) pipeline with a frame tracker that reports the
// peak bin, the peak power and the total energy once per NPTS-bin frame.
module fft_power_peak #(
  parameter int NPTS    = 256,
  parameter int LOG2N   = 8,
  parameter int SKIP_DC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [15:0]      in_re,
  input  logic signed [15:0]      in_im,
  output logic                    pwr_valid,
  output logic [31:0]             pwr,
  output logic [LOG2N-1:0]        pwr_bin,
  output logic                    frame_done,
  output logic [LOG2N-1:0]        peak_bin,
  output logic [31:0]             peak_pwr,
  output logic [LOG2N+31:0]       energy,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | no frame in progress
  // ACCUM  | bins 1..NPTS-1 of a frame are being accumulated
  // REPORT | results registered, frame_done high; bin 0 of a new frame may arrive
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [LOG2N-1:0] BIN_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(NPTS - 1);

  logic [1:0]         state_q, state_d;
  logic [LOG2N-1:0]   bin_cnt_q;

  logic               s1_valid_q;
  logic [LOG2N-1:0]   s1_bin_q;
  logic [31:0]        sq_re_q, sq_im_q;
  logic signed [31:0] prod_re, prod_im;

  logic               pwr_valid_q;
  logic [31:0]        pwr_q;
  logic [LOG2N-1:0]   pwr_bin_q;

  logic [LOG2N+31:0]  acc_q, acc_d;
  logic [31:0]        run_pk_q, run_pk_d;
  logic [LOG2N-1:0]   run_bin_q, run_bin_d;

  logic [LOG2N+31:0]  energy_q;
  logic [31:0]        peak_pwr_q;
  logic [LOG2N-1:0]   peak_bin_q;
  logic               report_load;

  assign prod_re = in_re * in_re;
  assign prod_im = in_im * in_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_bin_q    <= '0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      pwr_valid_q <= 1'b0;
      pwr_q       <= '0;
      pwr_bin_q   <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      pwr_valid_q <= s1_valid_q;
      if (in_valid) begin
        bin_cnt_q <= bin_cnt_q + BIN_ONE;
        sq_re_q   <= prod_re;
        sq_im_q   <= prod_im;
        s1_bin_q  <= bin_cnt_q;
      end
      // Squares are non-negative, so the unsigned sum peaks at exactly 2^31.
      if (s1_valid_q) begin
        pwr_q     <= sq_re_q + sq_im_q;
        pwr_bin_q <= s1_bin_q;
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    run_pk_d  = run_pk_q;
    run_bin_d = run_bin_q;
    if (pwr_valid_q) begin
      if (pwr_bin_q == '0) begin
        acc_d     = {{LOG2N{1'b0}}, pwr_q};
        run_pk_d  = (SKIP_DC != 0) ? 32'd0 : pwr_q;
        run_bin_d = (SKIP_DC != 0) ? BIN_ONE : '0;
      end else begin
        acc_d = acc_q + {{LOG2N{1'b0}}, pwr_q};
        if (pwr_q > run_pk_q) begin
          run_pk_d  = pwr_q;
          run_bin_d = pwr_bin_q;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pwr_valid_q && pwr_bin_q == '0) state_d = ACCUM;
      ACCUM:   if (pwr_valid_q && pwr_bin_q == LAST_BIN) state_d = REPORT;
      REPORT:  state_d = (pwr_valid_q && pwr_bin_q == '0) ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign report_load = (state_q == ACCUM) && (state_d == REPORT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      run_pk_q   <= '0;
      run_bin_q  <= '0;
      energy_q   <= '0;
      peak_pwr_q <= '0;
      peak_bin_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      run_pk_q  <= run_pk_d;
      run_bin_q <= run_bin_d;
      if (report_load) begin
        energy_q   <= acc_d;
        peak_pwr_q <= run_pk_d;
        peak_bin_q <= run_bin_d;
      end
    end
  end

  assign pwr_valid  = pwr_valid_q;
  assign pwr        = pwr_q;
  assign pwr_bin    = pwr_bin_q;
  assign frame_done = (state_q == REPORT);
  assign peak_bin   = peak_bin_q;
  assign peak_pwr   = peak_pwr_q;
  assign energy     = energy_q;
  assign busy       = (bin_cnt_q != '0) | s1_valid_q | pwr_valid_q;

endmodule

// File: tb/tb_fft_power_peak.sv
// Drives two instances (SKIP_DC=0 and SKIP_DC=1) with directed and random frames
// and checks every cycle against a frame-level reference model.
module tb_fft_power_peak;
  localparam int N  = 256;
  localparam int LG = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_re = '0, in_im = '0;

  logic            d0_pwr_valid, d1_pwr_valid, d0_frame_done, d1_frame_done, d0_busy, d1_busy;
  logic [31:0]     d0_pwr, d1_pwr, d0_peak_pwr, d1_peak_pwr;
  logic [LG-1:0]   d0_pwr_bin, d1_pwr_bin, d0_peak_bin, d1_peak_bin;
  logic [LG+31:0]  d0_energy, d1_energy;

  fft_power_peak #(.NPTS(N), .LOG2N(LG), .SKIP_DC(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .pwr_valid(d0_pwr_valid), .pwr(d0_pwr), .pwr_bin(d0_pwr_bin),
    .frame_done(d0_frame_done), .peak_bin(d0_peak_bin), .peak_pwr(d0_peak_pwr),
    .energy(d0_energy), .busy(d0_busy));

  fft_power_peak #(.NPTS(N), .LOG2N(LG), .SKIP_DC(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .pwr_valid(d1_pwr_valid), .pwr(d1_pwr), .pwr_bin(d1_pwr_bin),
    .frame_done(d1_frame_done), .peak_bin(d1_peak_bin), .peak_pwr(d1_peak_pwr),
    .energy(d1_energy), .busy(d1_busy));

  always #5 clk = ~clk;

  typedef struct {
    bit     v;
    longint p;
    int     bin;
    bit     done;
    longint e;
    longint pk0;
    int     pb0;
    longint pk1;
    int     pb1;
  } ent_t;

  ent_t   hist[$];
  longint frm[N];
  int     mbin;
  longint e_exp, pk0_exp, pk1_exp;
  int     pb0_exp, pb1_exp;
  int     nassert = 0, nfail = 0;
  int     edge_n = 0, last_done = -1, done_gap = 0;
  int     re_arr[N], im_arr[N];
  logic [63:0] sv_energy, sv_peak_pwr, sv_peak_bin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    ent_t z;
    z = '{default: 0};
    hist.delete();
    repeat (3) hist.push_back(z);
    mbin = 0;
    e_exp = 0; pk0_exp = 0; pk1_exp = 0; pb0_exp = 0; pb1_exp = 0;
  endtask

  task automatic check_outputs();
    ent_t ep, ed;
    ep = hist[1];
    ed = hist[0];
    chk("pwr_valid0", d0_pwr_valid, ep.v);
    chk("pwr_valid1", d1_pwr_valid, ep.v);
    if (ep.v) begin
      chk("pwr0", d0_pwr, ep.p);
      chk("pwr_bin0", d0_pwr_bin, ep.bin);
      chk("pwr1", d1_pwr, ep.p);
      chk("pwr_bin1", d1_pwr_bin, ep.bin);
    end
    chk("frame_done0", d0_frame_done, ed.done);
    chk("frame_done1", d1_frame_done, ed.done);
    if (d0_frame_done === 1'b1) begin
      if (last_done >= 0) done_gap = edge_n - last_done;
      last_done = edge_n;
    end
    if (ed.done) begin
      e_exp = ed.e; pk0_exp = ed.pk0; pb0_exp = ed.pb0; pk1_exp = ed.pk1; pb1_exp = ed.pb1;
    end
    chk("energy0", d0_energy, e_exp);
    chk("energy1", d1_energy, e_exp);
    chk("peak_pwr0", d0_peak_pwr, pk0_exp);
    chk("peak_bin0", d0_peak_bin, pb0_exp);
    chk("peak_pwr1", d1_peak_pwr, pk1_exp);
    chk("peak_bin1", d1_peak_bin, pb1_exp);
    chk("busy0", d0_busy, (mbin != 0) || hist[2].v || hist[1].v);
  endtask

  task automatic cyc(input bit v, input int re, input int im);
    ent_t e;
    longint r, i;
    e = '{default: 0};
    in_valid = v;
    in_re = 16'(re);
    in_im = 16'(im);
    if (v) begin
      r = longint'(in_re);
      i = longint'(in_im);
      e.v = 1'b1;
      e.p = r * r + i * i;
      e.bin = mbin;
      frm[mbin] = e.p;
      if (mbin == N - 1) begin
        e.done = 1'b1;
        e.pk0 = frm[0]; e.pb0 = 0;
        e.pk1 = frm[1]; e.pb1 = 1;
        for (int k = 0; k < N; k++) begin
          e.e += frm[k];
          if (frm[k] > e.pk0) begin e.pk0 = frm[k]; e.pb0 = k; end
          if (k >= 1 && frm[k] > e.pk1) begin e.pk1 = frm[k]; e.pb1 = k; end
        end
      end
      mbin = (mbin + 1) % N;
    end
    hist.push_back(e);
    if (hist.size() > 3) void'(hist.pop_front());
    @(posedge clk);
    #1;
    edge_n++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, int'($urandom_range(0, 65535)), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    @(posedge clk);
    #1;
    chk("rst_pwr_valid", d0_pwr_valid, 0);
    chk("rst_pwr", d0_pwr, 0);
    chk("rst_pwr_bin", d0_pwr_bin, 0);
    chk("rst_frame_done", d0_frame_done, 0);
    chk("rst_energy", d0_energy, 0);
    chk("rst_peak_pwr", d0_peak_pwr, 0);
    chk("rst_peak_bin", d1_peak_bin, 0);
    chk("rst_busy", d0_busy, 0);
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // all bins (1,1)
    for (int k = 0; k < N; k++) cyc(1'b1, 1, 1);
    idle(4);
    chk("t1_energy", d0_energy, 512);
    chk("t1_peak_bin", d0_peak_bin, 0);
    chk("t1_peak_pwr", d0_peak_pwr, 2);

    // single full-scale bin
    for (int k = 0; k < N; k++) cyc(1'b1, (k == 37) ? -32768 : 0, (k == 37) ? -32768 : 0);
    idle(4);
    chk("t2_energy", d0_energy, 64'h0_8000_0000);
    chk("t2_peak_bin", d0_peak_bin, 37);
    chk("t2_peak_pwr", d0_peak_pwr, 64'h8000_0000);

    // equal peaks at 10 and 200
    for (int k = 0; k < N; k++) cyc(1'b1, (k == 10 || k == 200) ? 100 : 0, 0);
    idle(3);
    chk("t3_peak_bin0", d0_peak_bin, 10);
    chk("t3_peak_pwr0", d0_peak_pwr, 10000);

    // same plus strong DC bin
    for (int k = 0; k < N; k++) cyc(1'b1, (k == 10 || k == 200) ? 100 : ((k == 0) ? 500 : 0), 0);
    idle(3);
    chk("t3b_peak_bin1", d1_peak_bin, 10);
    chk("t3b_energy1", d1_energy, 270000);
    chk("t3b_peak_bin0", d0_peak_bin, 0);

    // small-range random frame (frequent ties), gapless then with gaps
    for (int k = 0; k < N; k++) begin
      re_arr[k] = int'($urandom_range(0, 4)) - 2;
      im_arr[k] = int'($urandom_range(0, 4)) - 2;
    end
    for (int k = 0; k < N; k++) cyc(1'b1, re_arr[k], im_arr[k]);
    idle(4);
    sv_energy = d0_energy; sv_peak_pwr = d0_peak_pwr; sv_peak_bin = d0_peak_bin;
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, re_arr[k], im_arr[k]);
      cyc(1'b0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    idle(4);
    chk("gap_energy", d0_energy, sv_energy);
    chk("gap_peak_pwr", d0_peak_pwr, sv_peak_pwr);
    chk("gap_peak_bin", d0_peak_bin, sv_peak_bin);

    // full-range random frame
    for (int k = 0; k < N; k++)
      cyc(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    idle(4);

    // back-to-back frames
    for (int k = 0; k < N; k++) cyc(1'b1, 2, 0);
    for (int k = 0; k < N; k++) begin
      cyc(1'b1, 0, 3);
      if (k == 1) chk("b2b_energy_a", d0_energy, 1024);
    end
    idle(4);
    chk("b2b_energy_b", d0_energy, 2304);
    chk("b2b_done_gap", done_gap, 256);

    // reset mid-frame, then a clean frame
    for (int k = 0; k < 100; k++) cyc(1'b1, 1, 0);
    do_reset();
    for (int k = 0; k < N; k++) cyc(1'b1, 1, 0);
    idle(4);
    chk("rst_frame_energy", d0_energy, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
